// File: rtl/hilo_muldiv.sv
// ---------------------------------------------------------------------------
// hilo_muldiv
//
// Iterative multiply/divide unit holding the MIPS-style HI/LO register pair.
// A start request launches a 32-cycle radix-2 iteration on the operand
// magnitudes, followed by a single fix-up cycle. That fix-up cycle restores
// signs and handles divide-by-zero, then writes HI/LO.
//
// Ports
//   clk     : rising-edge clock
//   rst_b   : asynchronous active-low reset
//   start   : launch an operation (sampled with op, data_1, data_2)
//   op      : MULT / MULTU / DIV / DIVU select
//   data_1  : multiplicand or dividend (rs)
//   data_2  : multiplier or divisor (rt)
//   mthi    : write wdata into HI (honoured only when idle and not starting)
//   mtlo    : write wdata into LO (honoured only when idle and not starting)
//   wdata   : write data for mthi / mtlo
//   hi      : HI register (remainder or product[63:32])
//   lo      : LO register (quotient or product[31:0])
//   busy    : operation in flight; pipeline stalls mfhi/mflo on it
//   done    : one-cycle pulse when HI/LO first show a new result
// ---------------------------------------------------------------------------
module hilo_muldiv #(
  parameter int         WIDTH    = 32,
  parameter logic [1:0] OP_MULT  = 2'b00,
  parameter logic [1:0] OP_MULTU = 2'b01,
  parameter logic [1:0] OP_DIV   = 2'b10,
  parameter logic [1:0] OP_DIVU  = 2'b11
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Control state
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;

  // Operation context captured at start
  logic [1:0]         op_q, op_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;

  // Shared working register: {partial product, multiplier} for multiplies,
  // {partial remainder, dividend/quotient} for divides.
  logic [2*WIDTH-1:0] acc_q, acc_d;

  // Architectural result registers
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Operand preparation
  logic               op_signed;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  // Iteration datapath
  logic               is_div;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  // Fix-up results
  logic               div_zero;
  logic [WIDTH-1:0]   quo_mag;
  logic [WIDTH-1:0]   rem_mag;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  // Signed ops work on magnitudes; the signs are kept so the fix-up cycle can
  // restore them. Unsigned ops record both signs as positive, so the fix-up
  // for them degenerates to a pass-through.
  always_comb begin
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    neg_a     = op_signed & data_1[WIDTH-1];
    neg_b     = op_signed & data_2[WIDTH-1];
    mag_a     = neg_a ? -data_1 : data_1;
    mag_b     = neg_b ? -data_2 : data_2;
  end

  // One iteration step for each operation class.
  // Multiply: add the multiplicand when the current multiplier bit is set,
  // then shift the 65-bit {carry, partial, multiplier} right by one.
  // Divide: shift the next dividend bit into the partial remainder and
  // subtract the divisor if it fits. The subtraction only needs WIDTH bits
  // because the difference is always below the divisor when it is taken.
  always_comb begin
    is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + (acc_q[0] ? {1'b0, b_mag_q} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_mag_q});
    div_sub   = div_shift[WIDTH-1:0] - b_mag_q;
    div_rem   = div_ge ? div_sub : div_shift[WIDTH-1:0];
    div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};
  end

  // Final result formation in the fix-up cycle.
  // A signed multiply negates the whole 64-bit product when the signs
  // differ. A signed divide negates the quotient on differing signs, and
  // gives the remainder the dividend's sign. The -2^31 / -1 case needs no
  // special path: both signs are negative, so the magnitude quotient
  // 0x80000000 passes through unchanged. Divide by zero bypasses the
  // iteration result entirely.
  always_comb begin
    div_zero = (b_mag_q == '0);
    quo_mag  = acc_q[WIDTH-1:0];
    rem_mag  = acc_q[2*WIDTH-1:WIDTH];
    {res_hi, res_lo} = acc_q;
    case (op_q)
      OP_MULT: begin
        if (sign_a_q ^ sign_b_q) begin
          {res_hi, res_lo} = -acc_q;
        end
      end
      OP_MULTU: begin
        {res_hi, res_lo} = acc_q;
      end
      OP_DIV, OP_DIVU: begin
        if (div_zero) begin
          res_lo = '1;
          res_hi = a_raw_q;
        end else begin
          res_lo = (sign_a_q ^ sign_b_q) ? -quo_mag : quo_mag;
          res_hi = sign_a_q ? -rem_mag : rem_mag;
        end
      end
      default: begin
        {res_hi, res_lo} = acc_q;
      end
    endcase
  end

  // FSM next-state and register updates.
  // IDLE accepts start with priority over mthi/mtlo. CALC runs exactly
  // WIDTH iterations. FIX commits HI/LO and raises done for the next cycle.
  // HI/LO are untouched in every other situation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_raw_d  = a_raw_q;
    b_mag_d  = b_mag_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_CALC;
          cnt_d    = '0;
          op_d     = op;
          sign_a_d = neg_a;
          sign_b_d = neg_b;
          a_raw_d  = data_1;
          b_mag_d  = mag_b;
          acc_d    = {{WIDTH{1'b0}}, mag_a};
        end else begin
          if (mthi) begin
            hi_d = wdata;
          end
          if (mtlo) begin
            lo_d = wdata;
          end
        end
      end
      S_CALC: begin
        acc_d = is_div ? div_next : mul_next;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FIX: begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers. Reset abandons any operation in flight;
  // because HI/LO only load in FIX, no partial result can reach them.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      op_q     <= 2'b00;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_raw_q  <= '0;
      b_mag_q  <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_raw_q  <= a_raw_d;
      b_mag_q  <= b_mag_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// ---------------------------------------------------------------------------
// tb_hilo_muldiv
//
// Self-checking bench for hilo_muldiv. Each launched operation pushes its
// reference {hi, lo} onto a queue. A monitor pops and compares that entry
// whenever done pulses.
// ---------------------------------------------------------------------------
module tb_hilo_muldiv;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic        clk;
  logic        rst_b;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_1;
  logic [31:0] data_2;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int          checkCount = 0;
  int          failCount  = 0;
  logic [63:0] expQueue[$];
  logic [63:0] monExp;
  logic [63:0] ilExp;
  logic [31:0] hiBefore;
  logic [31:0] loBefore;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .start  (start),
    .op     (op),
    .data_1 (data_1),
    .data_2 (data_2),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .wdata  (wdata),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, observed no completion, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, actual, expected);
    end
  endtask

  // Reference model: {hi, lo} computed with native SystemVerilog arithmetic
  function automatic logic [63:0] modelResult(input logic [1:0] opIn, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    int          q;
    int          r;
    logic [63:0] res;
    case (opIn)
      OP_MULT: begin
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = sa * sb;
      end
      OP_MULTU: begin
        res = {32'd0, a} * {32'd0, b};
      end
      OP_DIV: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          res = {32'd0, 32'h8000_0000};
        end else begin
          q   = $signed(a) / $signed(b);
          r   = $signed(a) % $signed(b);
          res = {r, q};
        end
      end
      default: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          res = {a % b, a / b};
        end
      end
    endcase
    return res;
  endfunction

  // Scoreboard monitor: every done pulse consumes one expected result
  always @(negedge clk) begin
    if (rst_b === 1'b1 && done === 1'b1) begin
      if (expQueue.size() == 0) begin
        checkOutput("unexpectedDone", 64'd1, 64'd0);
      end else begin
        monExp = expQueue.pop_front();
        checkOutput("resultHi", {32'd0, hi}, {32'd0, monExp[63:32]});
        checkOutput("resultLo", {32'd0, lo}, {32'd0, monExp[31:0]});
      end
    end
  end

  // Called just after a falling edge: present a start for the next rising
  // edge, then scramble the operands once that edge has sampled them.
  task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] a, input logic [31:0] b, input bit expectResult);
    start    = 1'b1;
    op       = opIn;
    data_1   = a;
    data_2   = b;
    hiBefore = hi;
    loBefore = lo;
    if (expectResult) begin
      expQueue.push_back(modelResult(opIn, a, b));
    end
    @(negedge clk);
    start  = 1'b0;
    mthi   = 1'b0;
    mtlo   = 1'b0;
    data_1 = $urandom;
    data_2 = $urandom;
    op     = 2'($urandom);
  endtask

  // Counts busy cycles (bounded), checks HI/LO hold meanwhile and that done
  // is up once busy drops. Returns in the done cycle.
  task automatic checkLatency(input string tag);
    int cycles = 0;
    bit held   = 1'b1;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      if (hi !== hiBefore || lo !== loBefore) held = 1'b0;
      @(negedge clk);
    end
    checkOutput({tag, "_busyCycles"}, 64'(cycles), 64'd33);
    checkOutput({tag, "_holdHiLo"}, {63'd0, held}, 64'd1);
    checkOutput({tag, "_doneUp"}, {63'd0, done}, 64'd1);
  endtask

  task automatic runOp(input string tag, input logic [1:0] opIn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    applyStimulus(opIn, a, b, 1'b1);
    checkLatency(tag);
    @(negedge clk);
    checkOutput({tag, "_donePulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    rst_b  = 1'b0;
    start  = 1'b0;
    op     = 2'b00;
    data_1 = '0;
    data_2 = '0;
    mthi   = 1'b0;
    mtlo   = 1'b0;
    wdata  = '0;

    #12;
    checkOutput("resetHi", {32'd0, hi}, 64'd0);
    checkOutput("resetLo", {32'd0, lo}, 64'd0);
    checkOutput("resetBusy", {63'd0, busy}, 64'd0);
    checkOutput("resetDone", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // mthi/mtlo in idle, together and alone
    @(negedge clk);
    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'h1234_5678;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    checkOutput("mtBothHi", {32'd0, hi}, 64'h0000_0000_1234_5678);
    checkOutput("mtBothLo", {32'd0, lo}, 64'h0000_0000_1234_5678);
    mthi  = 1'b1;
    wdata = 32'hCAFE_F00D;
    @(negedge clk);
    mthi = 1'b0;
    checkOutput("mthiHi", {32'd0, hi}, 64'h0000_0000_CAFE_F00D);
    checkOutput("mthiLo", {32'd0, lo}, 64'h0000_0000_1234_5678);

    // Directed operations including sign and boundary cases
    runOp("mult",       OP_MULT,  32'hFFFF_FFFE, 32'd3);
    runOp("multu",      OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runOp("div",        OP_DIV,   32'hFFFF_FFF9, 32'd2);
    runOp("divuZero",   OP_DIVU,  32'd100,       32'd0);
    runOp("divZero",    OP_DIV,   32'h8000_0005, 32'd0);
    runOp("divOvf",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    runOp("divNegDsr",  OP_DIV,   32'd17,        32'hFFFF_FFFB);
    runOp("multMin",    OP_MULT,  32'h8000_0000, 32'h8000_0000);

    // start and mtlo in the same idle cycle: the write must be dropped
    @(negedge clk);
    mtlo  = 1'b1;
    wdata = 32'hDEAD_BEEF;
    applyStimulus(OP_MULTU, 32'd9, 32'd11, 1'b1);
    checkLatency("startPrio");
    @(negedge clk);
    checkOutput("startPrio_donePulse", {63'd0, done}, 64'd0);

    // Random operations
    for (int i = 0; i < 8; i++) begin
      runOp("rand", 2'($urandom), $urandom, (i % 2 == 1) ? $urandom : $urandom_range(1, 20));
    end

    // A start presented in the done cycle is accepted
    @(negedge clk);
    applyStimulus(OP_DIVU, 32'd1000, 32'd7, 1'b1);
    checkLatency("b2bFirst");
    applyStimulus(OP_MULT, 32'hFFFF_FF00, 32'h0000_0010, 1'b1);
    checkLatency("b2bSecond");
    @(negedge clk);
    checkOutput("b2b_donePulse", {63'd0, done}, 64'd0);

    // Busy interlock: late start and mtlo ignored, mthi in done cycle taken
    @(negedge clk);
    ilExp = modelResult(OP_MULT, 32'h0000_1234, 32'hFFFF_FF9C);
    applyStimulus(OP_MULT, 32'h0000_1234, 32'hFFFF_FF9C, 1'b1);
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      if (i == 4) begin
        start  = 1'b1;
        op     = OP_DIVU;
        data_1 = 32'd5;
        data_2 = 32'd1;
      end
      if (i == 5) start = 1'b0;
      if (i == 9) begin
        mtlo  = 1'b1;
        wdata = 32'h0BAD_0BAD;
      end
      if (i == 10) begin
        mtlo = 1'b0;
        checkOutput("busyMtloIgnored", {32'd0, lo}, {32'd0, loBefore});
      end
      if (i == 32) checkOutput("busyLastCycle", {63'd0, busy}, 64'd1);
      if (i == 33) begin
        checkOutput("busyDoneCycle", {63'd0, done}, 64'd1);
        mthi  = 1'b1;
        wdata = 32'h5555_AAAA;
      end
    end
    @(negedge clk);
    mthi = 1'b0;
    checkOutput("doneCycleMthiHi", {32'd0, hi}, 64'h0000_0000_5555_AAAA);
    checkOutput("doneCycleMthiLo", {32'd0, lo}, {32'd0, ilExp[31:0]});
    checkOutput("interlockNoRestart", {63'd0, busy}, 64'd0);

    // Reset in the middle of an operation
    @(negedge clk);
    applyStimulus(OP_MULTU, 32'd5, 32'd7, 1'b0);
    repeat (19) @(negedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    checkOutput("midResetHi", {32'd0, hi}, 64'd0);
    checkOutput("midResetLo", {32'd0, lo}, 64'd0);
    checkOutput("midResetBusy", {63'd0, busy}, 64'd0);
    checkOutput("midResetDone", {63'd0, done}, 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("heldResetBusy", {63'd0, busy}, 64'd0);
    rst_b = 1'b1;
    applyStimulus(OP_MULTU, 32'd5, 32'd7, 1'b1);
    checkLatency("afterReset");
    @(negedge clk);
    checkOutput("afterReset_donePulse", {63'd0, done}, 64'd0);

    repeat (2) @(negedge clk);
    checkOutput("queueDrained", 64'(expQueue.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 Parameter WIDTH, default 32: operand width; HI and LO are each WIDTH bits; only 32 is supported.
REQ-002 Parameter OP_* encoding: MULT=2'b00, MULTU=2'b01, DIV=2'b10, DIVU=2'b11.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_b  in  1  asynchronous active-low reset.
REQ-006 start  in  1  request to launch a multiply or divide; sampled on the rising clk edge.
REQ-007 op  in  2  operation select, per REQ-002; sampled with start.
REQ-008 data_1  in  32  multiplicand or dividend (rs); sampled with start.
REQ-009 data_2  in  32  multiplier or divisor (rt); sampled with start.
REQ-010 mthi  in  1  write wdata into HI.
REQ-011 mtlo  in  1  write wdata into LO.
REQ-012 wdata  in  32  write data for mthi and mtlo.
REQ-013 hi  out  32  HI register (remainder / product[63:32]).
REQ-014 lo  out  32  LO register (quotient / product[31:0]).
REQ-015 busy  out  1  high while an operation is in flight; the pipeline stalls mfhi/mflo on busy.
REQ-016 done  out  1  one-cycle pulse in the cycle HI/LO first show a new result.

Function
REQ-017 The block shall be a three-state FSM:
- IDLE: busy=0.
- CALC: busy=1; a 5-bit counter runs 0..31.
- FIX: busy=1.
- busy shall be decoded from state only: busy=1 iff state is not IDLE.
REQ-018 FSM transitions:
- IDLE with start=1 -> CALC; latch op and the operand magnitudes; counter=0.
- CALC -> FIX on the edge where the counter equals 31; otherwise increment the counter.
- FIX -> IDLE; write hi/lo; done=1 for the following cycle.
REQ-019 Latency: start sampled at edge N yields hi/lo updated and done=1 after edge N+33; busy=1 after edges N through N+32.
REQ-020 Start handling:
- start while busy=1 shall be ignored; no queueing.
- start in the done cycle shall be accepted.
REQ-021 Multiply: radix-2 shift-add, one partial-product bit per CALC cycle, on unsigned magnitudes.
REQ-022 MULT result: FIX applies two's-complement negation to the 64-bit product when the operand signs differ; MULTU applies no sign fix.
REQ-023 Divide: restoring division, one quotient bit per CALC cycle, on unsigned magnitudes.
REQ-024 DIV result:
- Quotient truncates toward zero.
- Remainder takes the sign of the dividend.
- -2^31 / -1 gives lo=32'h80000000, hi=0.
REQ-025 Divide by zero (DIV or DIVU): lo=32'hFFFFFFFF, hi=data_1 as latched; busy and latency are unchanged.
REQ-026 mthi/mtlo in IDLE:
- Each shall update its register at the clock edge.
- Both asserted together shall update both registers.
REQ-027 mthi/mtlo while busy=1 shall be ignored.
REQ-028 When start and mthi/mtlo are asserted in the same IDLE cycle, the write shall be ignored; start has priority.
REQ-029 hi/lo shall change only on a FIX->IDLE edge or an accepted mthi/mtlo; they shall hold across all other cycles, including CALC.
REQ-030 Operand inputs need not be held stable after the start edge.

Reset
REQ-031 rst_b=0 shall immediately force:
- state=IDLE, counter=0;
- hi=0, lo=0;
- busy=0, done=0.
REQ-032 rst_b asserted mid-operation shall abort the operation; no partial result shall reach hi/lo.
REQ-033 After rst_b deasserts, the first rising edge shall accept start.

Verification
REQ-034 MULT: data_1=32'hFFFFFFFE (-2), data_2=3 -> after edge N+33, hi=32'hFFFFFFFF, lo=32'hFFFFFFFA, done pulse for exactly 1 cycle.
REQ-035 MULTU: data_1=data_2=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-036 DIV: data_1=-7, data_2=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
REQ-037 DIVU: data_1=100, data_2=0 -> lo=32'hFFFFFFFF, hi=100, busy high for 33 cycles.
REQ-038 Busy interlock:
- start asserted again at cycle N+5 with different operands -> ignored; result matches the first operation.
- mtlo at N+10 -> ignored.
- mthi in the done cycle -> hi=wdata after that edge.
REQ-039 Reset mid-op: start MULTU 5x7, drop rst_b at cycle N+20 -> hi=lo=0, busy=0 immediately, no done pulse; a new start after release completes normally.
